// File: rtl/aibcr3_avmm_chan_if.sv
// AVMM sideband channel bus: adapter-side TX/RX words and pad-ring signals.
// master = adapter + pad ring; slave = aibcr3_avmm_chan.
interface aibcr3_avmm_chan_if #(
   parameter int NUM_RX = 2,
   parameter int NUM_TX = 1
) ();
   logic [NUM_TX-1:0] tx_idat0;
   logic [NUM_TX-1:0] tx_idat1;
   logic              tx_ivld;
   logic              tx_irdy;
   logic              tx_itxen;
   logic [NUM_TX-1:0] tx_pad_out;
   logic [NUM_TX-1:0] tx_pad_oe;
   logic [NUM_RX-1:0] rx_pad_in;
   logic [NUM_RX-1:0] rx_irxen;
   logic [NUM_RX-1:0] rx_odat0;
   logic [NUM_RX-1:0] rx_odat1;
   logic              rx_ovld;

   modport master (
      output tx_idat0, tx_idat1, tx_ivld, tx_itxen, rx_pad_in, rx_irxen,
      input  tx_irdy, tx_pad_out, tx_pad_oe, rx_odat0, rx_odat1, rx_ovld
   );

   modport slave (
      input  tx_idat0, tx_idat1, tx_ivld, tx_itxen, rx_pad_in, rx_irxen,
      output tx_irdy, tx_pad_out, tx_pad_oe, rx_odat0, rx_odat1, rx_ovld
   );
endinterface

// File: rtl/aibcr3_avmm_chan.sv
// AVMM sideband channel: 2:1 TX serialiser, 1:2 RX deserialiser, reset sequencer; TX pad 1 cycle after accept, RX pair 1 cycle after 2nd sample, rx_ovld 1 later.
// tx_irdy low outside ACTIVE and during the second TX half; RX never stalls. Boundary scan built only with AIBCR3_AVMM_BSCAN_EN.
module aibcr3_avmm_chan #(
   parameter int NUM_RX = 2,
   parameter int NUM_TX = 1,
   parameter int RSTDLY = 8
) (
   input  logic              avmm_clk,
   input  logic              avmm_rstb,
   aibcr3_avmm_chan_if.slave ch,
   input  logic              jtag_clkdr,
   input  logic              jtag_tx_scanen_in,
   input  logic              jtag_update,
   input  logic              jtag_mode_in,
   input  logic              jtag_intest,
   input  logic              jtag_scan_in,
   output logic              jtag_scan_out
);
   typedef enum logic [1:0] {
      ST_RST    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACTIVE = 2'd2
   } seq_state_t;

   seq_state_t state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       active;

   always_ff @(posedge avmm_clk) begin
      if (!avmm_rstb) begin
         state <= ST_RST;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RST: begin
            state_nxt = ST_WAIT;
            cnt_nxt   = '0;
         end
         ST_WAIT: begin
            if (cnt == 8'(RSTDLY - 1)) begin
               state_nxt = ST_ACTIVE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         ST_ACTIVE: state_nxt = ST_ACTIVE;
         default:   state_nxt = ST_RST;
      endcase
   end

   assign active = (state == ST_ACTIVE);

   // TX: word lands as idat0 then idat1; half blocks a new accept in between
   logic [NUM_TX-1:0] pad_q, hold_q, pad_mux;
   logic              half_q, tx_rdy, tx_acc;

   assign tx_rdy = active & ~half_q;
   assign tx_acc = ch.tx_ivld & tx_rdy;

   always_ff @(posedge avmm_clk) begin
      if (!avmm_rstb) begin
         pad_q  <= '0;
         hold_q <= '0;
         half_q <= 1'b0;
      end else if (tx_acc) begin
         pad_q  <= ch.tx_idat0;
         hold_q <= ch.tx_idat1;
         half_q <= 1'b1;
      end else begin
         pad_q  <= half_q ? hold_q : '0;
         half_q <= 1'b0;
      end
   end

   assign ch.tx_irdy    = tx_rdy;
   assign ch.tx_pad_out = pad_mux;

   logic [NUM_RX-1:0] rx_src;

`ifdef AIBCR3_AVMM_BSCAN_EN
   localparam int L = NUM_RX + NUM_TX;
   logic [L-1:0] sreg, ureg;

   always_ff @(posedge avmm_clk) begin
      if (!avmm_rstb) begin
         sreg <= '0;
         ureg <= '0;
      end else begin
         if (jtag_update)
            ureg <= sreg;
         if (jtag_clkdr) begin
            if (jtag_tx_scanen_in)
               sreg <= {sreg[L-2:0], jtag_scan_in};
            else
               sreg <= {pad_mux, ch.rx_pad_in};
         end
      end
   end

   // mode mux stays combinational so the scan owner drives pads even in reset
   assign pad_mux       = jtag_mode_in ? ureg[L-1:NUM_RX] : pad_q;
   assign ch.tx_pad_oe  = jtag_mode_in ? {NUM_TX{1'b1}} : {NUM_TX{active & ch.tx_itxen}};
   assign rx_src        = jtag_intest ? ureg[NUM_RX-1:0] : ch.rx_pad_in;
   assign jtag_scan_out = sreg[L-1];
`else
   logic unused_jtag;
   assign unused_jtag   = ^{jtag_clkdr, jtag_tx_scanen_in, jtag_update,
                            jtag_mode_in, jtag_intest, jtag_scan_in};
   assign pad_mux       = pad_q;
   assign ch.tx_pad_oe  = {NUM_TX{active & ch.tx_itxen}};
   assign rx_src        = ch.rx_pad_in;
   assign jtag_scan_out = 1'b0;
`endif

   logic [NUM_RX-1:0] rx_smp, even_q, odat0_q, odat1_q;
   logic              phase_q, done_q, ovld_q;

   assign rx_smp = rx_src & ch.rx_irxen;

   always_ff @(posedge avmm_clk) begin
      if (!avmm_rstb) begin
         even_q  <= '0;
         odat0_q <= '0;
         odat1_q <= '0;
         phase_q <= 1'b0;
         done_q  <= 1'b0;
         ovld_q  <= 1'b0;
      end else begin
         phase_q <= active & ~phase_q;
         done_q  <= active & phase_q;
         ovld_q  <= done_q;
         if (active) begin
            if (!phase_q) begin
               even_q <= rx_smp;
            end else begin
               odat0_q <= even_q;
               odat1_q <= rx_smp;
            end
         end
      end
   end

   assign ch.rx_odat0 = odat0_q;
   assign ch.rx_odat1 = odat1_q;
   assign ch.rx_ovld  = ovld_q;
endmodule

// File: tb/tb_aibcr3_avmm_chan.sv
// Bench for aibcr3_avmm_chan (NUM_RX=2, NUM_TX=2, RSTDLY=8): directed steps plus random traffic
// against a word-queue / sample-pair reference model; scan checks when AIBCR3_AVMM_BSCAN_EN is set.
module tb_aibcr3_avmm_chan;
   localparam int NR = 2;
   localparam int NT = 2;
   localparam int RD = 8;
   localparam int L  = NR + NT;

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   logic jclk = 1'b0, jscan = 1'b0, jupd = 1'b0, jmode = 1'b0, jintest = 1'b0, jsin = 1'b0;
   logic jsout;

   aibcr3_avmm_chan_if #(.NUM_RX(NR), .NUM_TX(NT)) bus ();

   aibcr3_avmm_chan #(.NUM_RX(NR), .NUM_TX(NT), .RSTDLY(RD)) dut (
      .avmm_clk          (clk),
      .avmm_rstb         (rstb),
      .ch                (bus),
      .jtag_clkdr        (jclk),
      .jtag_tx_scanen_in (jscan),
      .jtag_update       (jupd),
      .jtag_mode_in      (jmode),
      .jtag_intest       (jintest),
      .jtag_scan_in      (jsin),
      .jtag_scan_out     (jsout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int            since = -1;
   logic [NT-1:0] txq[$];
   logic [NT-1:0] exp_pad = '0;
   int            nsmp = 0;
   logic [NR-1:0] even_s = '0, exp_o0 = '0, exp_o1 = '0;
   logic          exp_ovld = 1'b0, pair_prev = 1'b0;
   logic [L-1:0]  ms = '0, mu = '0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NT-1:0] exp_txout();
`ifdef AIBCR3_AVMM_BSCAN_EN
      if (jmode) return mu[L-1:NR];
`endif
      return exp_pad;
   endfunction

   function automatic logic [NT-1:0] exp_oe();
`ifdef AIBCR3_AVMM_BSCAN_EN
      if (jmode) return {NT{1'b1}};
`endif
      return {NT{(since >= RD) && bus.tx_itxen}};
   endfunction

   function automatic logic [NR-1:0] exp_rxsrc();
`ifdef AIBCR3_AVMM_BSCAN_EN
      if (jintest) return mu[NR-1:0];
`endif
      return bus.rx_pad_in;
   endfunction

   task automatic step();
      logic          act_pre, acc;
      logic [NR-1:0] smp;
`ifdef AIBCR3_AVMM_BSCAN_EN
      logic [NT-1:0] txo_pre;
      logic [L-1:0]  ms_pre;
      txo_pre = exp_txout();
      ms_pre  = ms;
`endif
      act_pre = (since >= RD);
      acc     = bus.tx_ivld && act_pre && (txq.size() == 0);
      smp     = exp_rxsrc() & bus.rx_irxen;
      @(posedge clk);
      if (!rstb) begin
         since = -1;
         txq.delete();
         exp_pad = '0;
         nsmp = 0;
         even_s = '0; exp_o0 = '0; exp_o1 = '0;
         exp_ovld = 1'b0; pair_prev = 1'b0;
         ms = '0; mu = '0;
      end else begin
         if (since < RD) since++;
         if (acc) begin
            txq.push_back(bus.tx_idat0);
            txq.push_back(bus.tx_idat1);
         end
         if (txq.size() > 0) exp_pad = txq.pop_front();
         else                exp_pad = '0;
         exp_ovld  = pair_prev;
         pair_prev = 1'b0;
         if (act_pre) begin
            if (nsmp % 2 == 0) begin
               even_s = smp;
            end else begin
               exp_o0 = even_s;
               exp_o1 = smp;
               pair_prev = 1'b1;
            end
            nsmp++;
         end
`ifdef AIBCR3_AVMM_BSCAN_EN
         if (jupd) mu = ms_pre;
         if (jclk) ms = jscan ? {ms_pre[L-2:0], jsin} : {txo_pre, bus.rx_pad_in};
`endif
      end
      #1;
      chk("tx_pad_out", 8'(bus.tx_pad_out), 8'(exp_txout()));
      chk("tx_pad_oe",  8'(bus.tx_pad_oe),  8'(exp_oe()));
      chk("tx_irdy",    8'(bus.tx_irdy),    8'((since >= RD) && (txq.size() == 0)));
      chk("rx_odat0",   8'(bus.rx_odat0),   8'(exp_o0));
      chk("rx_odat1",   8'(bus.rx_odat1),   8'(exp_o1));
      chk("rx_ovld",    8'(bus.rx_ovld),    8'(exp_ovld));
`ifdef AIBCR3_AVMM_BSCAN_EN
      chk("scan_out",   8'(jsout),          8'(ms[L-1]));
`else
      chk("scan_out",   8'(jsout),          8'h00);
`endif
   endtask

   initial begin
      bus.tx_idat0  = '0;
      bus.tx_idat1  = '0;
      bus.tx_ivld   = 1'b0;
      bus.tx_itxen  = 1'b0;
      bus.rx_pad_in = '0;
      bus.rx_irxen  = '0;

      // reset, then release and watch tx_irdy rise on the RSTDLY-th edge after the first high sample
      repeat (3) step();
      rstb = 1'b1;
      for (int i = 0; i <= RD; i++) begin
         step();
         chk("irdy_seq", 8'(bus.tx_irdy), 8'(i == RD));
      end

      // TX back-to-back stream
      bus.tx_itxen = 1'b1;
      bus.tx_ivld  = 1'b1;
      bus.tx_idat0 = 2'b01; bus.tx_idat1 = 2'b10;
      step(); chk("tx_s0", 8'(bus.tx_pad_out), 8'h1);
      bus.tx_idat0 = 2'b11; bus.tx_idat1 = 2'b00;
      step(); chk("tx_s1", 8'(bus.tx_pad_out), 8'h2);
      step(); chk("tx_s2", 8'(bus.tx_pad_out), 8'h3);
      bus.tx_ivld = 1'b0;
      step(); chk("tx_s3", 8'(bus.tx_pad_out), 8'h0);
      step(); chk("tx_idle", 8'(bus.tx_pad_out), 8'h0);
      chk("tx_oe", 8'(bus.tx_pad_oe), 8'h3);

      // RX pair on lane 0, lane 1 masked
      if (nsmp % 2 != 0) step();
      bus.rx_irxen  = 2'b01;
      bus.rx_pad_in = 2'b01;
      step();
      bus.rx_pad_in = 2'b10;
      step();
      chk("rx_o0", 8'(bus.rx_odat0), 8'h1);
      chk("rx_o1", 8'(bus.rx_odat1), 8'h0);
      chk("rx_vld_early", 8'(bus.rx_ovld), 8'h0);
      step(); chk("rx_vld", 8'(bus.rx_ovld), 8'h1);
      step(); chk("rx_vld_end", 8'(bus.rx_ovld), 8'h0);
      bus.rx_pad_in = '0;

      // reset the cycle after an accept: idat1 is dropped
      if (txq.size() != 0) step();
      bus.tx_ivld  = 1'b1;
      bus.tx_idat0 = 2'b11; bus.tx_idat1 = 2'b11;
      step(); chk("rst_mid_acc", 8'(bus.tx_pad_out), 8'h3);
      bus.tx_ivld = 1'b0;
      rstb = 1'b0;
      step(); chk("rst_mid_drop", 8'(bus.tx_pad_out), 8'h0);
      rstb = 1'b1;
      for (int i = 0; i <= RD; i++) begin
         step();
         chk("rst_mid_pad", 8'(bus.tx_pad_out), 8'h0);
      end
      chk("rst_mid_irdy", 8'(bus.tx_irdy), 8'h1);

`ifdef AIBCR3_AVMM_BSCAN_EN
      // capture, shift out, shift in, update, drive pads, intest
      step(); step();
      bus.rx_pad_in = 2'b10;
      jclk = 1'b1; jscan = 1'b0;
      step(); chk("scan_c", 8'(jsout), 8'h0);
      jscan = 1'b1; jsin = 1'b0;
      step(); chk("scan_s1", 8'(jsout), 8'h0);
      step(); chk("scan_s2", 8'(jsout), 8'h1);
      step(); chk("scan_s3", 8'(jsout), 8'h0);
      jsin = 1'b1; step();
      jsin = 1'b0; step();
      jsin = 1'b1; step();
      jsin = 1'b1; step();
      jclk = 1'b0; jscan = 1'b0; jupd = 1'b1;
      step();
      jupd = 1'b0; jmode = 1'b1;
      step();
      chk("jmode_pad", 8'(bus.tx_pad_out), 8'h2);
      chk("jmode_oe",  8'(bus.tx_pad_oe),  8'h3);
      jintest = 1'b1; bus.rx_pad_in = 2'b00; bus.rx_irxen = 2'b11;
      repeat (4) step();
      jmode = 1'b0; jintest = 1'b0;
`endif

      // random traffic with occasional reset pulses and jtag noise
      for (int i = 0; i < 800; i++) begin
         bus.tx_ivld   = 1'($urandom_range(0, 1));
         bus.tx_idat0  = NT'($urandom);
         bus.tx_idat1  = NT'($urandom);
         bus.tx_itxen  = 1'($urandom_range(0, 1));
         bus.rx_pad_in = NR'($urandom);
         bus.rx_irxen  = NR'($urandom);
         jclk    = ($urandom_range(0, 3) == 0);
         jscan   = 1'($urandom_range(0, 1));
         jupd    = ($urandom_range(0, 7) == 0);
         jmode   = ($urandom_range(0, 5) == 0);
         jintest = ($urandom_range(0, 5) == 0);
         jsin    = 1'($urandom_range(0, 1));
         if (!rstb)                              rstb = 1'b1;
         else if ($urandom_range(0, 79) == 0)    rstb = 1'b0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
